// File: rtl/ysyx_23060201_isram_pkg.sv
// rtl/ysyx_23060201_isram_pkg.sv - shared constants, FSM encoding and memory image for the instruction SRAM
package ysyx_23060201_isram_pkg;

    localparam logic [31:0] MBASE       = 32'h8000_0000;
    localparam logic [31:0] MSIZE       = 32'h0800_0000;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [7:0]  LFSR_SEED   = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Physical memory image: word 0 holds 0x00000413, every other word is a
    // fixed hash of its word index. Byte lanes follow mask[3:0]; any upper
    // mask bit marks an illegal request and reads as zero.
    function automatic logic [31:0] pmem_read(input logic [31:0] addr, input logic [7:0] mask);
        logic [31:0] word_idx;
        logic [31:0] word;
        logic [31:0] lane_mask;
        word_idx  = (addr - MBASE) >> 2;
        word      = 32'h0000_0413 ^ (word_idx * 32'h9E37_79B9);
        lane_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        return (|mask[7:4]) ? 32'h0 : (word & lane_mask);
    endfunction

endpackage

// File: rtl/ysyx_23060201_lfsr8.sv
// rtl/ysyx_23060201_lfsr8.sv - free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1
module ysyx_23060201_lfsr8
    import ysyx_23060201_isram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic feedback;

    // Maximal-length taps: from a non-zero seed the all-zero state is unreachable.
    assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[6:0], feedback};
        end
    end

endmodule

// File: rtl/ysyx_23060201_isram.sv
// rtl/ysyx_23060201_isram.sv - read-only instruction memory slave with fixed or random wait states
module ysyx_23060201_isram
    import ysyx_23060201_isram_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LATENCY        = 1,
    parameter int RAND_DLY       = 0,
    parameter int DLY_BITS       = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MEM_ADDR_WIDTH-1:0] araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready
);

    localparam logic [MEM_ADDR_WIDTH:0] RANGE_LO = (MEM_ADDR_WIDTH+1)'(MBASE);
    localparam logic [MEM_ADDR_WIDTH:0] RANGE_HI = (MEM_ADDR_WIDTH+1)'(MBASE) + (MEM_ADDR_WIDTH+1)'(MSIZE);

    state_t                    state;
    logic [3:0]                cnt;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                lfsr_q;
    logic [3:0]                dly;
    logic                      addr_ok;
    logic                      lfsr_unused;

    ysyx_23060201_lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q;
    assign dly = (RAND_DLY != 0) ? 4'(lfsr_q[DLY_BITS-1:0]) : 4'(LATENCY);

    // One extra bit keeps MBASE+MSIZE from wrapping at the top of the address space.
    assign addr_ok = (addr_q[1:0] == 2'b00)
                  && ({1'b0, addr_q} >= RANGE_LO)
                  && ({1'b0, addr_q} <  RANGE_HI);

    assign arready = (state == ST_IDLE) & ~rst;
    assign rvalid  = (state == ST_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arvalid) begin
                        addr_q <= araddr;
                        cnt    <= dly;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        if (addr_ok) begin
                            rdata <= DATA_WIDTH'(pmem_read(32'(addr_q), 8'b0000_1111));
                            rresp <= RESP_OKAY;
                        end else begin
                            rdata <= '0;
                            rresp <= RESP_SLVERR;
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060201_isram.sv
// tb/tb_ysyx_23060201_isram.sv - scoreboard bench for the instruction SRAM slave
module tb_ysyx_23060201_isram;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr  [3];
    logic        arvalid [3];
    logic        arready [3];
    logic [31:0] rdata   [3];
    logic [1:0]  rresp   [3];
    logic        rvalid  [3];
    logic        rready  [3];

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ysyx_23060201_isram #(.LATENCY(0), .RAND_DLY(0)) dut0 (
        .clk(clk), .rst(rst), .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
        .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]));

    ysyx_23060201_isram #(.LATENCY(3), .RAND_DLY(0)) dut3 (
        .clk(clk), .rst(rst), .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
        .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]));

    ysyx_23060201_isram #(.LATENCY(1), .RAND_DLY(1), .DLY_BITS(3)) dutr (
        .clk(clk), .rst(rst), .araddr(araddr[2]), .arvalid(arvalid[2]), .arready(arready[2]),
        .rdata(rdata[2]), .rresp(rresp[2]), .rvalid(rvalid[2]), .rready(rready[2]));

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        if (a[1:0] == 2'b00 && a >= 32'h8000_0000 && a < 32'h8800_0000) return 2'b00;
        return 2'b10;
    endfunction

    function automatic logic [31:0] model_data(input logic [31:0] a);
        logic [31:0] w;
        if (model_resp(a) != 2'b00) return 32'h0;
        w = (a - 32'h8000_0000) >> 2;
        return 32'h0000_0413 ^ (w * 32'h9E37_79B9);
    endfunction

    task automatic ar_phase(input int idx, input logic [31:0] a,
                            output int lat, output bit busy_ok, output bit tmo);
        int   guard;
        exp_t e;
        lat = 0; guard = 0; busy_ok = 1'b1; tmo = 1'b0;
        araddr[idx]  = a;
        arvalid[idx] = 1'b1;
        while (arready[idx] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            arvalid[idx] = 1'b0;
            tmo = 1'b1;
            return;
        end
        e.data = model_data(a);
        e.resp = model_resp(a);
        sb.push_back(e);
        @(negedge clk);
        arvalid[idx] = 1'b0;
        araddr[idx]  = $urandom;
        while (rvalid[idx] !== 1'b1 && lat < 40) begin
            if (arready[idx] !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (arready[idx] !== 1'b0) busy_ok = 1'b0;
        if (lat >= 40) tmo = 1'b1;
    endtask

    task automatic r_phase(input int idx);
        rready[idx] = 1'b1;
        @(negedge clk);
        rready[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            arvalid[i] = 1'b0; rready[i] = 1'b0; araddr[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (arready[i] !== 1'b0) begin n_bad++; $display("FAIL reset_arready[%0d] got %b want 0", i, arready[i]); end
            n_cmp++; if (rvalid[i] !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid[%0d] got %b want 0", i, rvalid[i]); end
            n_cmp++; if (rdata[i] !== 32'h0) begin n_bad++; $display("FAIL reset_rdata[%0d] got %h want 0", i, rdata[i]); end
            n_cmp++; if (rresp[i] !== 2'b00) begin n_bad++; $display("FAIL reset_rresp[%0d] got %b want 00", i, rresp[i]); end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (arready[i] !== 1'b1) begin n_bad++; $display("FAIL idle_arready[%0d] got %b want 1", i, arready[i]); end
            n_cmp++; if (rvalid[i] !== 1'b0) begin n_bad++; $display("FAIL idle_rvalid[%0d] got %b want 0", i, rvalid[i]); end
        end
    endtask

    task automatic test_fixed_latency(input int idx, input logic [31:0] a, input int want_lat);
        int   lat; bit busy_ok; bit tmo; exp_t e;
        ar_phase(idx, a, lat, busy_ok, tmo);
        n_cmp++; if (tmo) begin n_bad++; $display("FAIL lat_timeout[%0d] addr %h timed out", idx, a); return; end
        e = sb.pop_front();
        n_cmp++; if (lat != want_lat) begin n_bad++; $display("FAIL latency[%0d] got %0d want %0d", idx, lat, want_lat); end
        n_cmp++; if (!busy_ok) begin n_bad++; $display("FAIL busy_arready[%0d] got 1 want 0 while busy", idx); end
        n_cmp++; if (rdata[idx] !== e.data) begin n_bad++; $display("FAIL lat_rdata[%0d] got %h want %h", idx, rdata[idx], e.data); end
        n_cmp++; if (rresp[idx] !== e.resp) begin n_bad++; $display("FAIL lat_rresp[%0d] got %b want %b", idx, rresp[idx], e.resp); end
        r_phase(idx);
        n_cmp++; if (rvalid[idx] !== 1'b0 || arready[idx] !== 1'b1) begin
            n_bad++; $display("FAIL lat_release[%0d] got rvalid=%b arready=%b want 0/1", idx, rvalid[idx], arready[idx]);
        end
    endtask

    task automatic test_backpressure();
        int lat; bit busy_ok; bit tmo; exp_t e;
        ar_phase(0, 32'h8000_0008, lat, busy_ok, tmo);
        n_cmp++; if (tmo) begin n_bad++; $display("FAIL bp_timeout got timeout want response"); return; end
        e = sb.pop_front();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (rvalid[0] !== 1'b1) begin n_bad++; $display("FAIL bp_rvalid cycle %0d got %b want 1", c, rvalid[0]); end
            n_cmp++; if (rdata[0] !== e.data || rresp[0] !== e.resp) begin
                n_bad++; $display("FAIL bp_hold cycle %0d got %h/%b want %h/%b", c, rdata[0], rresp[0], e.data, e.resp);
            end
            n_cmp++; if (arready[0] !== 1'b0) begin n_bad++; $display("FAIL bp_arready cycle %0d got %b want 0", c, arready[0]); end
        end
        r_phase(0);
        n_cmp++; if (rvalid[0] !== 1'b0 || arready[0] !== 1'b1) begin
            n_bad++; $display("FAIL bp_release got rvalid=%b arready=%b want 0/1", rvalid[0], arready[0]);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        int lat; bit busy_ok; bit tmo; exp_t e;
        addrs[0] = 32'h8000_0002; addrs[1] = 32'h7FFF_FFFC;
        addrs[2] = 32'h87FF_FFFC; addrs[3] = 32'h8800_0000;
        for (int i = 0; i < 4; i++) begin
            ar_phase(0, addrs[i], lat, busy_ok, tmo);
            n_cmp++; if (tmo) begin n_bad++; $display("FAIL err_timeout addr %h timed out", addrs[i]); continue; end
            e = sb.pop_front();
            n_cmp++; if (rresp[0] !== e.resp) begin n_bad++; $display("FAIL err_rresp addr %h got %b want %b", addrs[i], rresp[0], e.resp); end
            n_cmp++; if (rdata[0] !== e.data) begin n_bad++; $display("FAIL err_rdata addr %h got %h want %h", addrs[i], rdata[0], e.data); end
            r_phase(0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int guard = 0;
        bit seen = 1'b0;
        araddr[1]  = 32'h8000_0010;
        arvalid[1] = 1'b1;
        while (arready[1] !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        @(negedge clk);
        arvalid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (rvalid[1] !== 1'b0 || arready[1] !== 1'b0 || rdata[1] !== 32'h0) begin
            n_bad++; $display("FAIL midreset_outputs got rvalid=%b arready=%b rdata=%h want 0/0/0", rvalid[1], arready[1], rdata[1]);
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rvalid[1] !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL midreset_ghost got rvalid=1 want no response"); end
        n_cmp++; if (arready[1] !== 1'b1) begin n_bad++; $display("FAIL midreset_idle got arready=%b want 1", arready[1]); end
    endtask

    task automatic test_back_to_back();
        test_fixed_latency(1, 32'h8000_0100, 4);
        test_fixed_latency(1, 32'h8000_0104, 4);
    endtask

    task automatic test_random();
        int lat; bit busy_ok; bit tmo; exp_t e;
        logic [31:0] a;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
            ar_phase(2, a, lat, busy_ok, tmo);
            n_cmp++; if (tmo) begin n_bad++; $display("FAIL rnd_timeout #%0d addr %h", n, a); continue; end
            e = sb.pop_front();
            n_cmp++; if (lat < 1 || lat > 8) begin n_bad++; $display("FAIL rnd_latency #%0d got %0d want 1..8", n, lat); end
            n_cmp++; if (rdata[2] !== e.data || rresp[2] !== e.resp) begin
                n_bad++; $display("FAIL rnd_data #%0d addr %h got %h/%b want %h/%b", n, a, rdata[2], rresp[2], e.data, e.resp);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r_phase(2);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fixed_latency(0, 32'h8000_0000, 1);
        test_fixed_latency(1, 32'h8000_0004, 4);
        test_backpressure();
        test_errors();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
